// File: rtl/encoder_8_to_3_rr_if.sv
// Request/grant bundle of the sequential 8-to-3 encoder.
// The master drives requests, enable and ready; the slave (the encoder) returns the grant and status.
interface encoder_8_to_3_rr_if;
  logic [7:0] D;
  logic       E;
  logic       R;
  logic [2:0] Y;
  logic       V;
  logic [7:0] P;
  logic       GS;

  modport master (output D, E, R, input Y, V, P, GS);
  modport slave  (input D, E, R, output Y, V, P, GS);
endinterface

// File: rtl/encoder_8_to_3_rr.sv
// Sequential 8-to-3 request encoder: latches request lines into a pending register
// and serialises them into 3-bit indices over a valid/ready handshake.
module encoder_8_to_3_rr #(
  parameter bit ROUND_ROBIN = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  encoder_8_to_3_rr_if.slave   bus
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    VALID = 1'b1
  } state_t;

  state_t     state_r;
  logic [7:0] pend_r;
  logic [2:0] y_r;
  logic       v_r;
  logic [2:0] ptr_r;

  logic [2:0] sel_s;
  logic       xfer_s;
  logic [7:0] clr_s;

  function automatic logic [2:0] pick_fixed(input logic [7:0] req);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (req[i]) begin
        idx = 3'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  // Scan upward from the pointer; the 3-bit add wraps 7 -> 0 by itself.
  function automatic logic [2:0] pick_rr(input logic [7:0] req, input logic [2:0] ptr);
    logic [2:0] idx;
    logic [2:0] cand;
    logic       found;
    idx   = 3'd0;
    found = 1'b0;
    for (int k = 0; k < 8; k++) begin
      cand = ptr + 3'(k);
      if (req[cand] && !found) begin
        idx   = cand;
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    return idx;
  endfunction

  // Grant selection and transfer-edge clear mask.
  always_comb begin
    sel_s  = 3'd0;
    xfer_s = 1'b0;
    clr_s  = 8'h00;
    if (ROUND_ROBIN) begin
      sel_s = pick_rr(pend_r, ptr_r);
    end else begin
      sel_s = pick_fixed(pend_r);
    end
    xfer_s = (state_r == VALID) && bus.R;
    if (xfer_s) begin
      clr_s = 8'h01 << y_r;
    end else begin
      clr_s = 8'h00;
    end
  end

  // Pending register, grant FSM and rotation pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      pend_r  <= 8'h00;
      y_r     <= 3'd0;
      v_r     <= 1'b0;
      ptr_r   <= 3'd0;
    end else begin
      // Set wins over clear, so a re-request on the transfer edge stays pending.
      if (!bus.E) begin
        pend_r <= (pend_r & ~clr_s) | bus.D;
      end else begin
        pend_r <= pend_r & ~clr_s;
      end

      case (state_r)
        IDLE: begin
          if (!bus.E && (pend_r != 8'h00)) begin
            y_r     <= sel_s;
            v_r     <= 1'b1;
            state_r <= VALID;
          end else begin
            v_r     <= 1'b0;
            state_r <= IDLE;
          end
        end
        VALID: begin
          if (bus.R) begin
            v_r     <= 1'b0;
            state_r <= IDLE;
            if (ROUND_ROBIN) begin
              ptr_r <= y_r + 3'd1;
            end else begin
              ptr_r <= ptr_r;
            end
          end else begin
            v_r     <= 1'b1;
            state_r <= VALID;
          end
        end
        default: begin
          v_r     <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.Y  = y_r;
  assign bus.V  = v_r;
  assign bus.P  = pend_r;
  assign bus.GS = |pend_r;

endmodule

// File: tb/tb_encoder_8_to_3_rr.sv
// Bench for encoder_8_to_3_rr: fixed-priority and round-robin instances driven in lockstep,
// checked against a directed table, hand sequences and a random run against a reference model.
module tb_encoder_8_to_3_rr;

  logic       clk;
  logic       rst;
  logic [7:0] d_s;
  logic       e_s;
  logic       r_s;

  encoder_8_to_3_rr_if if_fp ();
  encoder_8_to_3_rr_if if_rr ();

  assign if_fp.D = d_s;
  assign if_fp.E = e_s;
  assign if_fp.R = r_s;
  assign if_rr.D = d_s;
  assign if_rr.E = e_s;
  assign if_rr.R = r_s;

  encoder_8_to_3_rr #(.ROUND_ROBIN(1'b0)) dut_fp (.clk(clk), .rst(rst), .bus(if_fp));
  encoder_8_to_3_rr #(.ROUND_ROBIN(1'b1)) dut_rr (.clk(clk), .rst(rst), .bus(if_rr));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model, index 0 = fixed priority, 1 = round robin.
  bit [7:0] m_p   [2];
  bit       m_v   [2];
  int       m_y   [2];
  int       m_ptr [2];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int choose(input int m, input bit [7:0] p);
    if (m == 1) begin
      for (int k = 0; k < 8; k++) if (p[(m_ptr[1] + k) % 8]) return (m_ptr[1] + k) % 8;
    end else begin
      for (int i = 7; i >= 0; i--) if (p[i]) return i;
    end
    return 0;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_p[m] = 8'h00; m_v[m] = 1'b0; m_y[m] = 0; m_ptr[m] = 0;
    end
  endtask

  task automatic model_step(input bit [7:0] d, input bit e, input bit r);
    bit [7:0] np;
    for (int m = 0; m < 2; m++) begin
      np = m_p[m];
      if (m_v[m] && r) np[m_y[m]] = 1'b0;
      if (!e) np = np | d;
      if (m_v[m]) begin
        if (r) begin
          m_v[m] = 1'b0;
          if (m == 1) m_ptr[m] = (m_y[m] + 1) % 8;
        end
      end else if (!e && m_p[m] != 8'h00) begin
        m_y[m] = choose(m, m_p[m]);
        m_v[m] = 1'b1;
      end
      m_p[m] = np;
    end
  endtask

  task automatic cycle(input logic [7:0] d, input logic e, input logic r);
    @(negedge clk);
    d_s = d; e_s = e; r_s = r;
    @(posedge clk);
    model_step(d, e, r);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    d_s = 8'h00; e_s = 1'b0; r_s = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic cmp_model(input string tag);
    chk({tag, "_fp_Y"}, int'(if_fp.Y), m_y[0]);
    chk({tag, "_fp_V"}, int'(if_fp.V), int'(m_v[0]));
    chk({tag, "_fp_P"}, int'(if_fp.P), int'(m_p[0]));
    chk({tag, "_fp_GS"}, int'(if_fp.GS), int'(m_p[0] != 8'h00));
    chk({tag, "_rr_Y"}, int'(if_rr.Y), m_y[1]);
    chk({tag, "_rr_V"}, int'(if_rr.V), int'(m_v[1]));
    chk({tag, "_rr_P"}, int'(if_rr.P), int'(m_p[1]));
    chk({tag, "_rr_GS"}, int'(if_rr.GS), int'(m_p[1] != 8'h00));
  endtask

  typedef struct {
    logic [7:0] d;
    logic       e;
    logic       r;
    logic [2:0] y_fp;
    logic       v_fp;
    logic [7:0] p_fp;
    logic [2:0] y_rr;
    logic       v_rr;
    logic [7:0] p_rr;
  } vec_t;

  vec_t tbl [20];

  initial begin
    int exp_idx;
    logic [7:0] rd;
    logic re;
    logic rr;

    tbl[0]  = '{8'h20, 1'b0, 1'b1, 3'd0, 1'b0, 8'h20, 3'd0, 1'b0, 8'h20};
    tbl[1]  = '{8'h00, 1'b0, 1'b1, 3'd5, 1'b1, 8'h20, 3'd5, 1'b1, 8'h20};
    tbl[2]  = '{8'h00, 1'b0, 1'b1, 3'd5, 1'b0, 8'h00, 3'd5, 1'b0, 8'h00};
    tbl[3]  = '{8'h81, 1'b0, 1'b1, 3'd5, 1'b0, 8'h81, 3'd5, 1'b0, 8'h81};
    tbl[4]  = '{8'h00, 1'b0, 1'b1, 3'd7, 1'b1, 8'h81, 3'd7, 1'b1, 8'h81};
    tbl[5]  = '{8'h00, 1'b0, 1'b1, 3'd7, 1'b0, 8'h01, 3'd7, 1'b0, 8'h01};
    tbl[6]  = '{8'h00, 1'b0, 1'b1, 3'd0, 1'b1, 8'h01, 3'd0, 1'b1, 8'h01};
    tbl[7]  = '{8'h00, 1'b0, 1'b1, 3'd0, 1'b0, 8'h00, 3'd0, 1'b0, 8'h00};
    tbl[8]  = '{8'h0A, 1'b0, 1'b1, 3'd0, 1'b0, 8'h0A, 3'd0, 1'b0, 8'h0A};
    tbl[9]  = '{8'h00, 1'b0, 1'b1, 3'd3, 1'b1, 8'h0A, 3'd1, 1'b1, 8'h0A};
    tbl[10] = '{8'h10, 1'b1, 1'b0, 3'd3, 1'b1, 8'h0A, 3'd1, 1'b1, 8'h0A};
    tbl[11] = '{8'h10, 1'b1, 1'b0, 3'd3, 1'b1, 8'h0A, 3'd1, 1'b1, 8'h0A};
    tbl[12] = '{8'h10, 1'b1, 1'b0, 3'd3, 1'b1, 8'h0A, 3'd1, 1'b1, 8'h0A};
    tbl[13] = '{8'h10, 1'b1, 1'b0, 3'd3, 1'b1, 8'h0A, 3'd1, 1'b1, 8'h0A};
    tbl[14] = '{8'h00, 1'b1, 1'b1, 3'd3, 1'b0, 8'h02, 3'd1, 1'b0, 8'h08};
    tbl[15] = '{8'h00, 1'b1, 1'b1, 3'd3, 1'b0, 8'h02, 3'd1, 1'b0, 8'h08};
    tbl[16] = '{8'h04, 1'b0, 1'b1, 3'd1, 1'b1, 8'h06, 3'd3, 1'b1, 8'h0C};
    tbl[17] = '{8'h0A, 1'b0, 1'b1, 3'd1, 1'b0, 8'h0E, 3'd3, 1'b0, 8'h0E};
    tbl[18] = '{8'h00, 1'b0, 1'b1, 3'd3, 1'b1, 8'h0E, 3'd1, 1'b1, 8'h0E};
    tbl[19] = '{8'h00, 1'b0, 1'b1, 3'd3, 1'b0, 8'h06, 3'd1, 1'b0, 8'h0C};

    rst = 1'b1; d_s = 8'h00; e_s = 1'b0; r_s = 1'b0;
    model_reset();
    #12;
    chk("rst_fp_Y", int'(if_fp.Y), 0);
    chk("rst_fp_V", int'(if_fp.V), 0);
    chk("rst_fp_P", int'(if_fp.P), 0);
    chk("rst_rr_GS", int'(if_rr.GS), 0);
    @(negedge clk);
    rst = 1'b0;

    // Directed table from reset.
    for (int i = 0; i < 20; i++) begin
      cycle(tbl[i].d, tbl[i].e, tbl[i].r);
      chk($sformatf("tbl%0d_fp_Y", i), int'(if_fp.Y), int'(tbl[i].y_fp));
      chk($sformatf("tbl%0d_fp_V", i), int'(if_fp.V), int'(tbl[i].v_fp));
      chk($sformatf("tbl%0d_fp_P", i), int'(if_fp.P), int'(tbl[i].p_fp));
      chk($sformatf("tbl%0d_fp_GS", i), int'(if_fp.GS), int'(tbl[i].p_fp != 8'h00));
      chk($sformatf("tbl%0d_rr_Y", i), int'(if_rr.Y), int'(tbl[i].y_rr));
      chk($sformatf("tbl%0d_rr_V", i), int'(if_rr.V), int'(tbl[i].v_rr));
      chk($sformatf("tbl%0d_rr_P", i), int'(if_rr.P), int'(tbl[i].p_rr));
    end

    // Round-robin fairness with all requests held high.
    do_reset();
    exp_idx = 0;
    for (int c = 0; c < 18; c++) begin
      cycle(8'hFF, 1'b0, 1'b1);
      chk("fair_rr_V", int'(if_rr.V), c % 2);
      chk("fair_rr_P", int'(if_rr.P), 8'hFF);
      chk("fair_fp_V", int'(if_fp.V), c % 2);
      if (c % 2 == 1) begin
        chk("fair_rr_Y", int'(if_rr.Y), exp_idx);
        chk("fair_fp_Y", int'(if_fp.Y), 7);
        exp_idx = (exp_idx + 1) % 8;
      end
    end
    chk("fair_wrap", exp_idx, 1);

    // Set-over-clear: a re-request on the transfer edge is served again.
    do_reset();
    cycle(8'h04, 1'b0, 1'b0);
    cycle(8'h00, 1'b0, 1'b0);
    chk("soc_grant_Y", int'(if_fp.Y), 2);
    chk("soc_grant_V", int'(if_fp.V), 1);
    cycle(8'h04, 1'b0, 1'b1);
    chk("soc_xfer_V", int'(if_fp.V), 0);
    chk("soc_keep_P", int'(if_fp.P), 8'h04);
    cycle(8'h00, 1'b0, 1'b0);
    chk("soc_again_Y", int'(if_fp.Y), 2);
    chk("soc_again_V", int'(if_fp.V), 1);

    // Reset between edges while a grant is outstanding.
    do_reset();
    cycle(8'h41, 1'b0, 1'b0);
    cycle(8'h00, 1'b0, 1'b0);
    chk("mid_pre_Y", int'(if_fp.Y), 6);
    chk("mid_pre_V", int'(if_fp.V), 1);
    chk("mid_pre_P", int'(if_fp.P), 8'h41);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_Y", int'(if_fp.Y), 0);
    chk("mid_rst_V", int'(if_fp.V), 0);
    chk("mid_rst_P", int'(if_fp.P), 0);
    chk("mid_rst_GS", int'(if_fp.GS), 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int c = 0; c < 4; c++) begin
      cycle(8'h00, 1'b0, 1'b1);
      chk("mid_idle_V", int'(if_fp.V), 0);
      chk("mid_idle_P", int'(if_fp.P), 0);
    end

    // Random traffic against the reference model.
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      rd = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      re = ($urandom_range(0, 7) == 0);
      rr = 1'($urandom_range(0, 1));
      cycle(rd, re, rr);
      cmp_model("rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
